imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//  Registered, parametrised RV32I/RV64I immediate extraction stage between fetch and decode.
//  Accepts one instruction per cycle over valid/ready and returns the sign/zero-extended
//  immediate, a format code and an illegal-opcode flag one cycle later.
//  A 2-entry skid buffer keeps full throughput under backpressure.
//  Adds AUIPC, FENCE, SYSTEM/CSR, correct shift-amount and XLEN=64 handling to the
//  combinational immediate generator.
// PARAMETERS
//  XLEN   32  immediate width; legal values 32 or 64 (any other value: $error at elaboration)
//  TAG_W  8   width of the sideband tag (e.g. PC index) carried alongside each instruction
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high
//  flush        in   1      discard all held entries (pipeline redirect)
//  in_valid     in   1      in_inst/in_tag valid
//  in_ready     out  1      stage can accept; transfer when in_valid && in_ready
//  in_inst      in   32     instruction word
//  in_tag       in   TAG_W  sideband, returned unchanged
//  out_valid    out  1      out_* valid
//  out_ready    in   1      consumer accepts; transfer when out_valid && out_ready
//  out_imm      out  XLEN   extended immediate
//  out_fmt      out  3      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM
//  out_illegal  out  1      opcode not in the table below
//  out_tag      out  TAG_W  tag of the output entry
//  illegal_cnt  out  16     only with IMM_ILLEGAL_CNT_EN
// BEHAVIOUR
//  Reset: out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, in_ready=1, both entries empty.
//  Buffer states: EMPTY -> ONE on accept; ONE -> TWO on accept with out_valid && !out_ready;
//   ONE -> EMPTY on drain without accept; TWO -> ONE on drain; no accept in TWO.
//  in_ready is registered: 1 in EMPTY and ONE, 0 in TWO.
//  Latency: accept at edge N -> out_valid at N+1; with out_ready held at 1, one result per cycle, no bubbles.
//  out_* hold stable while out_valid && !out_ready. Strict in-order delivery, no loss or duplication.
//  flush: both entries dropped at that edge; next cycle out_valid=0 and in_ready=1.
//   flush has priority over a same-cycle accept; the accepted word is discarded.
//  Decode by in_inst[6:0]; sext = sign-extend to XLEN from the top bit shown:
//   0000011 LOAD, 0010011 OP-IMM (funct3 not 001/101), 1100111 JALR
//    -> I: sext(inst[31:20])
//   0010011 with funct3 001/101 -> SHAMT: zero-extend inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64)
//   0100011 -> S: sext({inst[31:25],inst[11:7]})
//   1100011 -> B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})
//   0110111 LUI, 0010111 AUIPC -> U: sext({inst[31:12],12'b0}) (upper 32 bits = inst[31] at XLEN=64)
//   1101111 -> J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})
//   1110011 with funct3[2]=1 -> ZIMM: zero-extend inst[19:15];
//    funct3[2]=0 -> I: sext(inst[31:20])
//   0001111 FENCE -> NONE, imm 0, legal
//   any other opcode -> NONE, imm 0, out_illegal=1
//  Decode is computed at accept time and stored per entry; the output mux only selects the head entry.
// CONFIGURATION
//  IMM_ILLEGAL_CNT_EN defined: port illegal_cnt is present. It counts illegal entries delivered
//   (out_valid && out_ready && out_illegal), saturates at 16'hFFFF, cleared by reset only
//   (not by flush), reset value 0.
//  Undefined: the port and counter are absent; all other behaviour is identical.
// TESTING
//  1 reset 2 cycles -> all outputs 0, in_ready=1; release -> in_ready stays 1
//  2 XLEN=32, inst 32'hFFF00093 (addi -1), out_ready=1 -> next cycle out_imm=32'hFFFFFFFF, fmt=1
//  3 inst 32'h4030D093 (srai x1,x1,3) -> out_imm=3, fmt=6;
//    inst 32'hFE000EE3 (beq -4) -> out_imm=32'hFFFFFFFC, fmt=3
//  4 XLEN=64, inst 32'h800000B7 (lui) -> out_imm=64'hFFFFFFFF80000000, fmt=4;
//    inst 32'h0000007F -> out_illegal=1, imm=0, illegal_cnt=1 (macro defined)
//  5 out_ready=0, 3 back-to-back words tagged 1,2,3 -> in_ready=0 after tag 2 accepted;
//    out_ready=1 -> tags 1,2,3 delivered in order, no duplicates
//  6 two entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1;
//    the flushed-cycle word is never delivered

Source files
------------

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RV32I/RV64I immediate extraction stage with 2-entry skid buffer
// Optional illegal-entry counter port enabled by IMM_ILLEGAL_CNT_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
`ifdef IMM_ILLEGAL_CNT_EN
  output logic [15:0]      illegal_cnt,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ZIMM  = 3'd7;

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [XLEN-1:0]  imm_q [2];
  logic [XLEN-1:0]  imm_d [2];
  logic [2:0]       fmt_q [2];
  logic [2:0]       fmt_d [2];
  logic             ill_q [2];
  logic             ill_d [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [TAG_W-1:0] tag_d [2];

  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_ill;
  logic             accept;
  logic             drain;

  // Immediate decode of the incoming word; the result is stored with the entry.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (in_inst[6:0])
      7'b0000011, 7'b1100111: begin
        dec_imm = XLEN'($signed(in_inst[31:20]));
        dec_fmt = FMT_I;
      end
      7'b0010011: begin
        if (in_inst[14:12] == 3'b001 || in_inst[14:12] == 3'b101) begin
          dec_imm = (XLEN == 64) ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);
          dec_fmt = FMT_SHAMT;
        end else begin
          dec_imm = XLEN'($signed(in_inst[31:20]));
          dec_fmt = FMT_I;
        end
      end
      7'b0100011: begin
        dec_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
        dec_fmt = FMT_S;
      end
      7'b1100011: begin
        dec_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                 in_inst[11:8], 1'b0}));
        dec_fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        dec_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
        dec_fmt = FMT_U;
      end
      7'b1101111: begin
        dec_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                 in_inst[30:21], 1'b0}));
        dec_fmt = FMT_J;
      end
      7'b1110011: begin
        if (in_inst[14]) begin
          dec_imm = XLEN'(in_inst[19:15]);
          dec_fmt = FMT_ZIMM;
        end else begin
          dec_imm = XLEN'($signed(in_inst[31:20]));
          dec_fmt = FMT_I;
        end
      end
      7'b0001111: begin
        dec_fmt = FMT_NONE;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  assign out_valid   = (state_q != S_EMPTY);
  assign in_ready    = in_ready_q;
  assign accept      = in_valid && in_ready_q;
  assign drain       = out_valid && out_ready;
  assign out_imm     = imm_q[0];
  assign out_fmt     = fmt_q[0];
  assign out_illegal = ill_q[0];
  assign out_tag     = tag_q[0];

  // Entry 0 is always the head; entry 1 only fills when the head is stalled.
  always_comb begin
    state_d = state_q;
    imm_d   = imm_q;
    fmt_d   = fmt_q;
    ill_d   = ill_q;
    tag_d   = tag_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          imm_d[0] = dec_imm;
          fmt_d[0] = dec_fmt;
          ill_d[0] = dec_ill;
          tag_d[0] = in_tag;
          state_d  = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && drain) begin
          imm_d[0] = dec_imm;
          fmt_d[0] = dec_fmt;
          ill_d[0] = dec_ill;
          tag_d[0] = in_tag;
        end else if (accept) begin
          imm_d[1] = dec_imm;
          fmt_d[1] = dec_fmt;
          ill_d[1] = dec_ill;
          tag_d[1] = in_tag;
          state_d  = S_TWO;
        end else if (drain) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (drain) begin
          imm_d[0] = imm_q[1];
          fmt_d[0] = fmt_q[1];
          ill_d[0] = ill_q[1];
          tag_d[0] = tag_q[1];
          state_d  = S_ONE;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
    if (flush) begin
      state_d = S_EMPTY;
    end
    in_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      for (int k = 0; k < 2; k++) begin
        imm_q[k] <= '0;
        fmt_q[k] <= '0;
        ill_q[k] <= 1'b0;
        tag_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      imm_q      <= imm_d;
      fmt_q      <= fmt_d;
      ill_q      <= ill_d;
      tag_q      <= tag_d;
    end
  end

`ifdef IMM_ILLEGAL_CNT_EN
  logic [15:0] ill_cnt_q, ill_cnt_d;

  // Counts deliveries, not accepts, so flushed words never contribute.
  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (drain && out_illegal && ill_cnt_q != 16'hFFFF) begin
      ill_cnt_d = ill_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ill_cnt_q <= '0;
    end else begin
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign illegal_cnt = ill_cnt_q;
`endif

endmodule
